eth_frame_loopback: RTL and testbench
=====================================

# eth_frame_loopback

Parametrised N-channel store-and-forward Ethernet frame loopback, placed between the receive and transmit logic-side ports of per-channel RGMII MACs, all in the MAC transmit clock domain. Each channel buffers a received frame, commits it only if it ends with a good CRC and no error or overflow, and replays it as a continuous byte stream with a programmable inter-frame gap. An optional mode swaps the destination and source MAC addresses.

## Interface
- `CH_COUNT`, 4: number of independent channels, 1..8.
- `DEPTH`, 2048: buffer bytes per channel, power of 2, ≥64; AW = log2(DEPTH).
- `IFG`, 12: idle cycles (valid low) after each transmitted eof, 1..255.
- `SWAP_MAC`, 0: 1 = exchange bytes 0–5 with bytes 6–11 on output.

Ports:
- `clk` in 1: single clock (MAC gtx clock, 125 MHz).
- `rstn` in 1: asynchronous active-low reset.
- `rx_data` in CH_COUNT*8: receive byte, channel x at [x*8 +: 8].
- `rx_valid` in CH_COUNT: byte valid.
- `rx_sof` in CH_COUNT: first byte of frame (qualified by valid).
- `rx_eof` in CH_COUNT: last byte of frame (qualified by valid).
- `rx_crc_good` in CH_COUNT: sampled in the rx_eof cycle only.
- `rx_fr_err` in CH_COUNT: frame error, any cycle between sof and eof inclusive.
- `tx_data` out CH_COUNT*8: transmit byte.
- `tx_valid` out CH_COUNT: byte valid.
- `tx_sof` out CH_COUNT: first transmit byte.
- `tx_eof` out CH_COUNT: last transmit byte.
- `drop_o` out CH_COUNT: 1-cycle pulse per discarded frame.

## Operation
- Per channel: DEPTH×9 RAM (8 data + eof flag); AW+1-bit pointers `wr_ptr` (speculative), `wr_commit`, `rd_ptr`. Used = wr_ptr − rd_ptr; full when used == DEPTH.
- RX FSM: IDLE → FRAME on valid&sof; bytes written at wr_ptr, wr_ptr++. Byte written while full sets sticky `ovf`; that byte and the rest of the frame are not written.
- On valid&eof: commit (wr_commit ← wr_ptr+1, eof flag stored on that byte) iff crc_good & !err & !ovf & length ≥ 14; otherwise wr_ptr ← wr_commit and drop_o pulses. Return to IDLE.
- sof while in FRAME: current frame dropped (drop_o pulse), new frame starts at wr_commit. valid without sof in IDLE: ignored.
- Frame of exactly DEPTH bytes into an empty buffer is accepted.
- TX FSM: IDLE → READ when wr_commit ≠ rd_ptr; DATA streams one byte per cycle, tx_valid continuous, until the byte with eof flag; → GAP for IFG cycles; → IDLE. rd_ptr ← end+1 on the eof byte, freeing space to RX the next cycle.
- SWAP_MAC=1: read address offset i maps to i+6 for i<6, i−6 for 6≤i<12, i otherwise; the 14-byte minimum guarantees validity.
- Channels fully independent; no shared arbitration.

## Timing
- Reset: all outputs 0, pointers 0, FSMs IDLE, ovf/err cleared. Reset mid-frame discards all buffered data; outputs go 0 immediately (async).
- Outputs registered. With TX idle, rx eof sampled at edge E0 → tx_sof/tx_valid high after edge E0+3.
- During a frame, tx_valid never drops between sof and eof; tx_sof and tx_eof each high exactly one cycle (both high only if length were 1, which cannot occur).
- Between tx_eof and the next tx_sof: exactly IFG cycles valid low if a frame is already committed.
- Simultaneous RX write/commit and TX free in one cycle: both applied; full uses registered pointers (conservative by one cycle, no corruption).
- Pointer wrap: AW+1-bit modular arithmetic; frames may span the RAM end.

## Test plan
- Ch0 64-byte frame 00..3F, crc_good=1, SWAP_MAC=0 → identical 64 bytes out, sof on 00, eof on 3F, valid continuous, sof 3 edges after rx eof; drop_o stays 0.
- SWAP_MAC=1, dst FF:FF:FF:FF:FF:FF, src 00:11:22:33:44:55, 60 bytes → out dst 00:11:22:33:44:55, src FF×6, bytes 12–59 unchanged.
- 64-byte frame with crc_good=0, then one with fr_err mid-frame, then a good frame → two drop_o pulses, only the third frame output.
- DEPTH=64: 70-byte frame → dropped, drop_o pulse, buffer empty; following 64-byte frame → output intact.
- CH_COUNT=4, IFG=12: three back-to-back 60-byte frames on ch0 plus one on ch2 concurrently → ch0 gaps exactly 12 cycles, ch2 output unaffected, ch1/ch3 tx_valid 0.
- 10-byte frame → dropped; then rstn low during a 200-byte transmit → outputs 0 at once, no output after release until a new frame arrives.

Source files
------------

// File: rtl/eth_frame_loopback_if.sv
// eth_frame_loopback_if: per-channel rx/tx byte streams between the MAC logic-side ports and the loopback
//   rx_data/rx_valid/rx_sof/rx_eof/rx_crc_good/rx_fr_err : receive side, driven by the MAC (master)
//   tx_data/tx_valid/tx_sof/tx_eof/drop_o                : transmit side and drop pulses, driven by the loopback (slave)
interface eth_frame_loopback_if #(
  parameter int CH_COUNT = 4
);
  logic [CH_COUNT*8-1:0] rx_data;
  logic [CH_COUNT-1:0] rx_valid, rx_sof, rx_eof, rx_crc_good, rx_fr_err;
  logic [CH_COUNT*8-1:0] tx_data;
  logic [CH_COUNT-1:0] tx_valid, tx_sof, tx_eof, drop_o;
  modport master (
    output rx_data, rx_valid, rx_sof, rx_eof, rx_crc_good, rx_fr_err,
    input tx_data, tx_valid, tx_sof, tx_eof, drop_o
  );
  modport slave (
    input rx_data, rx_valid, rx_sof, rx_eof, rx_crc_good, rx_fr_err,
    output tx_data, tx_valid, tx_sof, tx_eof, drop_o
  );
endinterface

// File: rtl/eth_frame_loopback.sv
// eth_frame_loopback: N-channel store-and-forward Ethernet frame loopback with CRC/error filtering and IFG
//   clk  : MAC gtx clock, all channels
//   rstn : asynchronous active-low reset
//   bus  : slave side of eth_frame_loopback_if (rx stream in, tx stream and drop pulses out)
module eth_frame_loopback #(
  parameter int CH_COUNT = 4,
  parameter int DEPTH = 2048,
  parameter int IFG = 12,
  parameter bit SWAP_MAC = 0
) (
  input logic clk,
  input logic rstn,
  eth_frame_loopback_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] SIX = (AW+1)'(6);
  localparam logic [AW:0] TWELVE = (AW+1)'(12);
  typedef enum logic {R_IDLE, R_FRAME} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_READ, T_DATA, T_GAP} tx_state_t;
  genvar c;
  for (c = 0; c < CH_COUNT; c++) begin : g_ch
    logic [8:0] mem [DEPTH];
    logic [8:0] q;
    rx_state_t rs, rs_n;
    tx_state_t ts, ts_n;
    logic [AW:0] wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr, rd_ptr_n, base, off, off_n, moff;
    logic [AW-1:0] raddr;
    logic [3:0] len, len_n, cur_len;
    logic [7:0] gcnt, gcnt_n, td;
    logic ovf, ovf_n, err, err_n, dr, drop_n, start, in_fr, cur_ovf, cur_err, full, we, eof, ok;
    logic qv, qv_n, qs, qs_n, tv, tsf, te;
    always_comb begin
      start = bus.rx_valid[c] & bus.rx_sof[c];
      in_fr = start | (rs == R_FRAME);
      // a sof inside a frame restarts at the committed point, discarding the partial frame
      base = (rs == R_FRAME && !start) ? wr_ptr : wr_commit;
      cur_ovf = !start & ovf;
      cur_err = (!start & err) | bus.rx_fr_err[c];
      cur_len = start ? 4'd0 : len;
      full = (base - rd_ptr) == FULL;
      we = bus.rx_valid[c] & in_fr & !cur_ovf & !full;
      eof = bus.rx_valid[c] & in_fr & bus.rx_eof[c];
      len_n = (bus.rx_valid[c] && cur_len != 4'hf) ? cur_len + 4'd1 : cur_len;
      ok = bus.rx_crc_good[c] & !cur_err & !cur_ovf & !full & (len_n >= 4'd14);
      rs_n = rs;
      wr_ptr_n = wr_ptr;
      wr_commit_n = wr_commit;
      ovf_n = ovf;
      err_n = err;
      drop_n = start & (rs == R_FRAME);
      if (eof) begin
        rs_n = R_IDLE;
        ovf_n = 1'b0;
        err_n = 1'b0;
        wr_ptr_n = ok ? base + ONE : wr_commit;
        wr_commit_n = ok ? base + ONE : wr_commit;
        drop_n = drop_n | !ok;
      end else if (in_fr) begin
        rs_n = R_FRAME;
        err_n = cur_err;
        ovf_n = cur_ovf | (bus.rx_valid[c] & full);
        wr_ptr_n = base + (AW+1)'(we);
      end
    end
    always_comb begin
      moff = off;
      if (SWAP_MAC) moff = off < SIX ? off + SIX : off < TWELVE ? off - SIX : off;
      raddr = rd_ptr[AW-1:0] + moff[AW-1:0];
      ts_n = ts;
      rd_ptr_n = rd_ptr;
      off_n = off;
      gcnt_n = gcnt;
      qv_n = 1'b0;
      qs_n = 1'b0;
      case (ts)
        T_READ: begin
          ts_n = T_DATA;
          qv_n = 1'b1;
          qs_n = 1'b1;
          off_n = off + ONE;
        end
        T_DATA: begin
          // reads run one byte ahead; the byte fetched after the eof byte is discarded
          if (qv & q[8]) begin
            rd_ptr_n = rd_ptr + off;
            off_n = '0;
            gcnt_n = 8'(IFG - 2);
            ts_n = IFG == 1 ? (wr_commit != rd_ptr + off ? T_READ : T_IDLE) : T_GAP;
          end else begin
            qv_n = 1'b1;
            off_n = off + ONE;
          end
        end
        T_GAP: begin
          gcnt_n = gcnt - 8'd1;
          if (gcnt == 8'd0) ts_n = wr_commit != rd_ptr ? T_READ : T_IDLE;
        end
        default: begin
          off_n = '0;
          ts_n = wr_commit != rd_ptr ? T_READ : T_IDLE;
        end
      endcase
    end
    always_ff @(posedge clk) begin
      if (we) mem[base[AW-1:0]] <= {eof & ok, bus.rx_data[c*8 +: 8]};
      q <= mem[raddr];
    end
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rs <= R_IDLE;
        ts <= T_IDLE;
        wr_ptr <= '0;
        wr_commit <= '0;
        rd_ptr <= '0;
        off <= '0;
        len <= '0;
        gcnt <= '0;
        ovf <= 1'b0;
        err <= 1'b0;
        dr <= 1'b0;
        qv <= 1'b0;
        qs <= 1'b0;
        td <= '0;
        tv <= 1'b0;
        tsf <= 1'b0;
        te <= 1'b0;
      end else begin
        rs <= rs_n;
        ts <= ts_n;
        wr_ptr <= wr_ptr_n;
        wr_commit <= wr_commit_n;
        rd_ptr <= rd_ptr_n;
        off <= off_n;
        len <= len_n;
        gcnt <= gcnt_n;
        ovf <= ovf_n;
        err <= err_n;
        dr <= drop_n;
        qv <= qv_n;
        qs <= qs_n;
        td <= qv ? q[7:0] : 8'd0;
        tv <= qv;
        tsf <= qs;
        te <= qv & q[8];
      end
    end
    assign bus.tx_data[c*8 +: 8] = td;
    assign bus.tx_valid[c] = tv;
    assign bus.tx_sof[c] = tsf;
    assign bus.tx_eof[c] = te;
    assign bus.drop_o[c] = dr;
  end
endmodule

// File: tb/tb_eth_frame_loopback.sv
// tb_eth_frame_loopback: directed checks of a 4-channel loopback and a 1-channel 64-byte swap-mode loopback
module tb_eth_frame_loopback;
  typedef struct {int dv; int ch; logic [7:0] d; logic s; logic e; int t;} rec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int drops0 [4] = '{default: 0};
  int drops1 = 0;
  rec_t cap[$];
  logic [7:0] fbuf [256];
  logic [7:0] exp_b [256];
  always #4 clk = ~clk;
  eth_frame_loopback_if #(.CH_COUNT(4)) b0();
  eth_frame_loopback_if #(.CH_COUNT(1)) b1();
  eth_frame_loopback #(.CH_COUNT(4), .DEPTH(2048), .IFG(12), .SWAP_MAC(0)) dut0 (.clk(clk), .rstn(rstn), .bus(b0.slave));
  eth_frame_loopback #(.CH_COUNT(1), .DEPTH(64), .IFG(3), .SWAP_MAC(1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1.slave));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (b0.tx_valid[c]) cap.push_back('{0, c, b0.tx_data[c*8 +: 8], b0.tx_sof[c], b0.tx_eof[c], cyc});
      if (b0.drop_o[c]) drops0[c] <= drops0[c] + 1;
    end
    if (b1.tx_valid[0]) cap.push_back('{1, 0, b1.tx_data[7:0], b1.tx_sof[0], b1.tx_eof[0], cyc});
    if (b1.drop_o[0]) drops1 <= drops1 + 1;
  end
  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  function automatic int count(input int dv, input int ch, input int from);
    int n = 0;
    for (int i = from; i < cap.size(); i++) if (cap[i].dv == dv && cap[i].ch == ch) n++;
    return n;
  endfunction
  task automatic fill(input logic [7:0] base, input bit sw);
    for (int i = 0; i < 256; i++) fbuf[i] = base + 8'(i);
    for (int i = 0; i < 256; i++) exp_b[i] = sw ? fbuf[i < 6 ? i + 6 : i < 12 ? i - 6 : i] : fbuf[i];
  endtask
  task automatic chk_frame(input string tag, input int dv, input int ch, input int from, input int k, input int len,
                           output int ts, output int te);
    rec_t r[$];
    int bad_d = 0, bad_f = 0, bad_t = 0;
    for (int i = from; i < cap.size(); i++) if (cap[i].dv == dv && cap[i].ch == ch) r.push_back(cap[i]);
    ts = -1;
    te = -1;
    chk({tag, " avail"}, int'(r.size() >= (k + 1) * len), 1);
    if (r.size() >= (k + 1) * len) begin
      for (int i = 0; i < len; i++) begin
        if (r[k*len+i].d !== exp_b[i]) bad_d++;
        if (r[k*len+i].s !== (i == 0) || r[k*len+i].e !== (i == len - 1)) bad_f++;
        if (i > 0 && r[k*len+i].t != r[k*len+i-1].t + 1) bad_t++;
      end
      ts = r[k*len].t;
      te = r[k*len+len-1].t;
      chk({tag, " data"}, bad_d, 0);
      chk({tag, " sof_eof"}, bad_f, 0);
      chk({tag, " valid_gapless"}, bad_t, 0);
    end
  endtask
  task automatic idle0();
    b0.rx_data = '0; b0.rx_valid = '0; b0.rx_sof = '0; b0.rx_eof = '0; b0.rx_crc_good = '0; b0.rx_fr_err = '0;
  endtask
  task automatic idle1();
    b1.rx_data = '0; b1.rx_valid = '0; b1.rx_sof = '0; b1.rx_eof = '0; b1.rx_crc_good = '0; b1.rx_fr_err = '0;
  endtask
  task automatic send0(input logic [3:0] m, input int len, input bit crc, input int err_at, output int te);
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < 4; c++) b0.rx_data[c*8 +: 8] = fbuf[i];
      b0.rx_valid = m;
      b0.rx_sof = i == 0 ? m : 4'h0;
      b0.rx_eof = i == len - 1 ? m : 4'h0;
      b0.rx_crc_good = (i == len - 1 && crc) ? m : 4'h0;
      b0.rx_fr_err = i == err_at ? m : 4'h0;
      @(posedge clk); #1;
    end
    te = cyc;
    idle0();
  endtask
  task automatic send1(input int len, output int te);
    for (int i = 0; i < len; i++) begin
      b1.rx_data = fbuf[i];
      b1.rx_valid = 1'b1;
      b1.rx_sof = i == 0;
      b1.rx_eof = i == len - 1;
      b1.rx_crc_good = i == len - 1;
      b1.rx_fr_err = 1'b0;
      @(posedge clk); #1;
    end
    te = cyc;
    idle1();
  endtask
  initial begin
    int mk, e0, e1, ts, te, d0, d1, ts0, te0, ts1, te1, ts2;
    idle0();
    idle1();
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx_valid0", int'(b0.tx_valid), 0);
    chk("reset tx_data0", int'(b0.tx_data), 0);
    chk("reset drop0", int'(b0.drop_o), 0);
    chk("reset tx_valid1", int'(b1.tx_valid), 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mk = cap.size();
    d0 = drops0[0];
    fill(8'h00, 1'b0);
    send0(4'b0001, 64, 1'b1, -1, e0);
    repeat (90) @(posedge clk);
    #1;
    chk_frame("good64", 0, 0, mk, 0, 64, ts, te);
    chk("good64 latency", ts, e0 + 3);
    chk("good64 count", count(0, 0, mk), 64);
    chk("good64 nodrop", drops0[0] - d0, 0);
    mk = cap.size();
    fill(8'h00, 1'b0);
    for (int i = 0; i < 6; i++) fbuf[i] = 8'hff;
    for (int i = 6; i < 12; i++) fbuf[i] = 8'(17 * (i - 6));
    for (int i = 0; i < 6; i++) exp_b[i] = 8'(17 * i);
    for (int i = 6; i < 12; i++) exp_b[i] = 8'hff;
    send1(60, e1);
    repeat (80) @(posedge clk);
    #1;
    chk_frame("swap60", 1, 0, mk, 0, 60, ts, te);
    chk("swap60 latency", ts, e1 + 3);
    chk("swap60 count", count(1, 0, mk), 60);
    mk = cap.size();
    d0 = drops0[0];
    fill(8'h40, 1'b0);
    send0(4'b0001, 64, 1'b0, -1, e0);
    fill(8'h80, 1'b0);
    send0(4'b0001, 64, 1'b1, 20, e0);
    fill(8'hc0, 1'b0);
    send0(4'b0001, 64, 1'b1, -1, e0);
    repeat (90) @(posedge clk);
    #1;
    chk("bad crc/err drops", drops0[0] - d0, 2);
    chk("third only count", count(0, 0, mk), 64);
    chk_frame("third", 0, 0, mk, 0, 64, ts, te);
    chk("third latency", ts, e0 + 3);
    mk = cap.size();
    d1 = drops1;
    fill(8'h20, 1'b0);
    send1(70, e1);
    repeat (10) @(posedge clk);
    #1;
    chk("ovf drop", drops1 - d1, 1);
    chk("ovf nothing out", count(1, 0, mk), 0);
    fill(8'h40, 1'b1);
    send1(64, e1);
    repeat (90) @(posedge clk);
    #1;
    chk("depth64 count", count(1, 0, mk), 64);
    chk_frame("depth64", 1, 0, mk, 0, 64, ts, te);
    chk("depth64 latency", ts, e1 + 3);
    mk = cap.size();
    fill(8'h10, 1'b0);
    send0(4'b0101, 60, 1'b1, -1, e0);
    fill(8'h20, 1'b0);
    send0(4'b0001, 60, 1'b1, -1, te);
    fill(8'h30, 1'b0);
    send0(4'b0001, 60, 1'b1, -1, te);
    repeat (300) @(posedge clk);
    #1;
    chk("b2b ch0 count", count(0, 0, mk), 180);
    fill(8'h10, 1'b0);
    chk_frame("b2b f0", 0, 0, mk, 0, 60, ts0, te0);
    chk("b2b f0 latency", ts0, e0 + 3);
    chk_frame("ch2", 0, 2, mk, 0, 60, ts, te);
    chk("ch2 latency", ts, e0 + 3);
    chk("ch2 count", count(0, 2, mk), 60);
    fill(8'h20, 1'b0);
    chk_frame("b2b f1", 0, 0, mk, 1, 60, ts1, te1);
    chk("b2b gap1", ts1 - te0, 13);
    fill(8'h30, 1'b0);
    chk_frame("b2b f2", 0, 0, mk, 2, 60, ts2, te);
    chk("b2b gap2", ts2 - te1, 13);
    chk("ch1 silent", count(0, 1, mk), 0);
    chk("ch3 silent", count(0, 3, mk), 0);
    mk = cap.size();
    d0 = drops0[0];
    fill(8'h50, 1'b0);
    send0(4'b0001, 10, 1'b1, -1, e0);
    repeat (10) @(posedge clk);
    #1;
    chk("runt drop", drops0[0] - d0, 1);
    chk("runt nothing out", count(0, 0, mk), 0);
    send0(4'b0001, 200, 1'b1, -1, e0);
    repeat (53) @(posedge clk);
    #1;
    chk("mid tx valid", int'(b0.tx_valid[0]), 1);
    rstn = 1'b0;
    #1;
    chk("async reset valid", int'(b0.tx_valid), 0);
    chk("async reset data", int'(b0.tx_data), 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    mk = cap.size();
    repeat (300) @(posedge clk);
    #1;
    chk("post reset silent", count(0, 0, mk), 0);
    fill(8'h60, 1'b0);
    send0(4'b0001, 64, 1'b1, -1, e0);
    repeat (90) @(posedge clk);
    #1;
    chk_frame("post reset frame", 0, 0, mk, 0, 64, ts, te);
    chk("post reset latency", ts, e0 + 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
